// File: rtl/alu_flag_unit.sv
// A/B registers, adder/subtractor, flags and output register of the 8-bit computer datapath.
// Optional signed overflow flag enabled by defining ALU_OVERFLOW_FLAG_EN.
module alu_flag_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ai,
    input  logic             ao,
    input  logic             alo,
    input  logic             sub,
    input  logic             bi,
    input  logic             oi,
    input  logic             fe,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_drive,
    output logic             bus_conflict,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
`ifdef ALU_OVERFLOW_FLAG_EN
    output logic             overflow_flag,
`endif
    output logic [WIDTH-1:0] a_val
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] b_operand;
    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;

    // Subtraction is A + ~B + 1, so carry out high means no borrow (A >= B unsigned).
    always_comb begin
        b_operand = sub ? ~b_q : b_q;
        alu_sum   = {1'b0, a_q} + {1'b0, b_operand} + {{WIDTH{1'b0}}, sub};
        alu_r     = alu_sum[WIDTH-1:0];
        alu_c     = alu_sum[WIDTH];
    end

    always_comb begin
        bus_out = '0;
        if (alo) begin
            bus_out = alu_r;
        end else if (ao) begin
            bus_out = a_q;
        end
        bus_drive    = ao | alo;
        bus_conflict = ao & alo;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        a_d         = ai ? bus_in : a_q;
        b_d         = bi ? bus_in : b_q;
        out_d       = oi ? bus_in : out_q;
        out_valid_d = oi;
    end

    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (fe) begin
            if (alo) begin
                carry_d = alu_c;
                zero_d  = (alu_r == '0);
            end else begin
                carry_d = 1'b0;
                zero_d  = (a_q == '0);
            end
        end
    end

`ifdef ALU_OVERFLOW_FLAG_EN
    logic ovf_q, ovf_d;
    logic alu_ovf;

    // Overflow when both adder inputs share a sign and the result's sign differs;
    // using the inverted B operand covers subtraction with the same test.
    always_comb begin
        alu_ovf = (a_q[MSB] == b_operand[MSB]) && (alu_r[MSB] != a_q[MSB]);
        ovf_d   = ovf_q;
        if (fe) begin
            ovf_d = alo ? alu_ovf : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_flag = ovf_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

    assign a_val      = a_q;
    assign out_data   = out_q;
    assign out_valid  = out_valid_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed scoreboard bench for alu_flag_unit; overflow steps run when ALU_OVERFLOW_FLAG_EN is defined.
module tb_alu_flag_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ai = 1'b0, ao = 1'b0, alo = 1'b0, sub = 1'b0;
    logic       bi = 1'b0, oi = 1'b0, fe = 1'b0;
    logic       loop_bus = 1'b0;
    logic [7:0] ext_bus = 8'h00;
    logic [7:0] bus_in, bus_out, out_data, a_val;
    logic       bus_drive, bus_conflict, carry_flag, zero_flag, out_valid;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic       overflow_flag;
`endif

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // External bus mux: loop back this block's drive, otherwise another source.
    assign bus_in = loop_bus ? bus_out : ext_bus;

    alu_flag_unit #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .ai           (ai),
        .ao           (ao),
        .alo          (alo),
        .sub          (sub),
        .bi           (bi),
        .oi           (oi),
        .fe           (fe),
        .bus_in       (bus_in),
        .bus_out      (bus_out),
        .bus_drive    (bus_drive),
        .bus_conflict (bus_conflict),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
        .out_data     (out_data),
        .out_valid    (out_valid),
`ifdef ALU_OVERFLOW_FLAG_EN
        .overflow_flag(overflow_flag),
`endif
        .a_val        (a_val)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $error("FAIL scoreboard_empty: got %h with no expected value queued", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                tests_failed++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ai = 0; ao = 0; alo = 0; sub = 0; bi = 0; oi = 0; fe = 0;
        loop_bus = 0;
    endtask

    task automatic load_a(input logic [7:0] v);
        ai = 1; ext_bus = v;
        step();
        idle();
    endtask

    task automatic load_b(input logic [7:0] v);
        bi = 1; ext_bus = v;
        step();
        idle();
    endtask

    initial begin
        // Power-on reset
        step(); step();
        expect_val("rst_a", 8'h00);      check(a_val);
        expect_val("rst_out", 8'h00);    check(out_data);
        expect_val("rst_carry", 8'h00);  check({7'b0, carry_flag});
        expect_val("rst_zero", 8'h00);   check({7'b0, zero_flag});
        expect_val("rst_valid", 8'h00);  check({7'b0, out_valid});

        // Build up state, then reset in the middle of activity
        reset = 0;
        load_a(8'h55);
        expect_val("act_a", 8'h55);      check(a_val);
        bi = 1; oi = 1; ext_bus = 8'hC0;
        step(); idle();
        expect_val("act_out", 8'hC0);    check(out_data);
        expect_val("act_valid", 8'h01);  check({7'b0, out_valid});
        alo = 1; fe = 1; #1;
        expect_val("act_sum", 8'h15);    check(bus_out);
        expect_val("act_drive", 8'h01);  check({7'b0, bus_drive});
        step(); idle();
        expect_val("act_carry", 8'h01);  check({7'b0, carry_flag});
        reset = 1; ai = 1; oi = 1; fe = 1; alo = 1; ext_bus = 8'hAA;
        step(); reset = 0; idle();
        expect_val("mid_rst_a", 8'h00);     check(a_val);
        expect_val("mid_rst_out", 8'h00);   check(out_data);
        expect_val("mid_rst_carry", 8'h00); check({7'b0, carry_flag});
        expect_val("mid_rst_zero", 8'h00);  check({7'b0, zero_flag});
        expect_val("mid_rst_valid", 8'h00); check({7'b0, out_valid});
        alo = 1; #1;
        expect_val("mid_rst_b", 8'h00);     check(bus_out);
        idle();

        // ADD with carry, result written back to A
        load_a(8'hF0); load_b(8'h20);
        ai = 1; alo = 1; fe = 1; loop_bus = 1; #1;
        expect_val("add_bus", 8'h10);       check(bus_out);
        expect_val("add_noconf", 8'h00);    check({7'b0, bus_conflict});
        step(); idle();
        expect_val("add_a", 8'h10);         check(a_val);
        expect_val("add_carry", 8'h01);     check({7'b0, carry_flag});
        expect_val("add_zero", 8'h00);      check({7'b0, zero_flag});

        // LDA-style: load A with fe=0 (flags hold), then fe=1 with alo=0
        load_a(8'h00);
        expect_val("hold_carry", 8'h01);    check({7'b0, carry_flag});
        expect_val("hold_zero", 8'h00);     check({7'b0, zero_flag});
        fe = 1; step(); idle();
        expect_val("lda0_zero", 8'h01);     check({7'b0, zero_flag});
        expect_val("lda0_carry", 8'h00);    check({7'b0, carry_flag});
        load_a(8'h01);
        fe = 1; step(); idle();
        expect_val("lda1_zero", 8'h00);     check({7'b0, zero_flag});

        // SUB to zero
        load_a(8'h07); load_b(8'h07);
        sub = 1; alo = 1; ai = 1; fe = 1; loop_bus = 1; #1;
        expect_val("subz_bus", 8'h00);      check(bus_out);
        step(); idle();
        expect_val("subz_a", 8'h00);        check(a_val);
        expect_val("subz_carry", 8'h01);    check({7'b0, carry_flag});
        expect_val("subz_zero", 8'h01);     check({7'b0, zero_flag});

        // Output strobe with fe=0: flags must stay at carry=1, zero=1
        load_a(8'h2A);
        ao = 1; oi = 1; loop_bus = 1; #1;
        expect_val("out_bus", 8'h2A);       check(bus_out);
        expect_val("out_drive", 8'h01);     check({7'b0, bus_drive});
        step(); idle();
        expect_val("out_data", 8'h2A);      check(out_data);
        expect_val("out_valid1", 8'h01);    check({7'b0, out_valid});
        step();
        expect_val("out_valid0", 8'h00);    check({7'b0, out_valid});
        expect_val("out_carry", 8'h01);     check({7'b0, carry_flag});
        expect_val("out_zero", 8'h01);      check({7'b0, zero_flag});
        oi = 1; ext_bus = 8'h11; step();
        expect_val("b2b_valid1", 8'h01);    check({7'b0, out_valid});
        ext_bus = 8'h22; step(); idle();
        expect_val("b2b_valid2", 8'h01);    check({7'b0, out_valid});
        expect_val("b2b_data", 8'h22);      check(out_data);
        step();
        expect_val("b2b_valid3", 8'h00);    check({7'b0, out_valid});

        // SUB with borrow
        load_a(8'h03); load_b(8'h05);
        sub = 1; alo = 1; ai = 1; fe = 1; loop_bus = 1; #1;
        expect_val("subb_bus", 8'hFE);      check(bus_out);
        step(); idle();
        expect_val("subb_a", 8'hFE);        check(a_val);
        expect_val("subb_carry", 8'h00);    check({7'b0, carry_flag});
        expect_val("subb_zero", 8'h00);     check({7'b0, zero_flag});

        // Bus conflict: ALU wins priority
        ao = 1; alo = 1; #1;
        expect_val("conf_flag", 8'h01);     check({7'b0, bus_conflict});
        expect_val("conf_bus", 8'h03);      check(bus_out);
        alo = 0; #1;
        expect_val("ao_only_conf", 8'h00);  check({7'b0, bus_conflict});
        expect_val("ao_only_bus", 8'hFE);   check(bus_out);
        idle(); #1;
        expect_val("idle_drive", 8'h00);    check({7'b0, bus_drive});
        expect_val("idle_bus", 8'h00);      check(bus_out);

        // Simultaneous ai and ao: A reloads from the bus
        ai = 1; ao = 1; ext_bus = 8'h33; step(); idle();
        expect_val("aiao_a", 8'h33);        check(a_val);

`ifdef ALU_OVERFLOW_FLAG_EN
        load_a(8'h7F); load_b(8'h01);
        alo = 1; fe = 1; #1;
        expect_val("ovf_add_bus", 8'h80);   check(bus_out);
        step(); idle();
        expect_val("ovf_add", 8'h01);       check({7'b0, overflow_flag});
        expect_val("ovf_add_carry", 8'h00); check({7'b0, carry_flag});
        load_a(8'h80);
        sub = 1; alo = 1; fe = 1; #1;
        expect_val("ovf_sub_bus", 8'h7F);   check(bus_out);
        step(); idle();
        expect_val("ovf_sub", 8'h01);       check({7'b0, overflow_flag});
        expect_val("ovf_sub_carry", 8'h01); check({7'b0, carry_flag});
        fe = 1; step(); idle();
        expect_val("ovf_clear", 8'h00);     check({7'b0, overflow_flag});
        load_a(8'h10);
        alo = 1; fe = 1; step(); idle();
        expect_val("ovf_none", 8'h00);      check({7'b0, overflow_flag});
`endif

        tests_run++;
        assert (sb_q.size() === 0) else begin
            tests_failed++;
            $error("FAIL sb_drain: got %0d leftover expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Datapath stage directly downstream of the control unit and upstream of its flag inputs.
- Holds the A register, B register, adder/subtractor, flags register and output register of the 8-bit computer.
- Consumes the AI/AO/ALO/SUB/BI/OI/FE control bits and exchanges data with the shared bus.
- Returns carry_flag and zero_flag to the control unit for JC/JZ.

Parameters:
- WIDTH, 8, data width of A, B, ALU, bus and output register.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- ai  input  1  A register in (control bit 8)
- ao  input  1  A register out (control bit 7)
- alo  input  1  ALU out (control bit 6)
- sub  input  1  0 = add, 1 = subtract (control bit 5)
- bi  input  1  B register in (control bit 4)
- oi  input  1  output register in (control bit 3)
- fe  input  1  flags register enable (control bit 15)
- bus_in  input  WIDTH  current value of the shared bus
- bus_out  output  WIDTH  value this block drives onto the bus
- bus_drive  output  1  high when this block drives the bus
- bus_conflict  output  1  high when ao and alo are both asserted
- carry_flag  output  1  registered carry flag
- zero_flag  output  1  registered zero flag
- out_data  output  WIDTH  output register contents
- out_valid  output  1  one-cycle strobe, high the cycle after an output register load
- a_val  output  WIDTH  A register contents (debug/display)

Behaviour:
- Reset: synchronous, sampled on the rising clk edge. On reset, A, B, out_data, carry_flag, zero_flag and out_valid are all 0. Reset overrides every control input in the same cycle.
- A register: when ai=1, loads bus_in at the clock edge; otherwise holds.
- B register: when bi=1, loads bus_in at the clock edge; otherwise holds.
- ALU (combinational):
  - Add (sub=0): {c, r} = A + B, computed WIDTH+1 bits wide.
  - Subtract (sub=1): {c, r} = A + ~B + 1. Here c=1 means no borrow, i.e. A >= B unsigned.
  - Sum wraps modulo 2^WIDTH.
- Bus drive:
  - bus_drive = ao | alo.
  - alo has priority: bus_out = r when alo=1, else A when ao=1, else 0.
  - bus_conflict = ao & alo, combinational.
- Flags (fe=1, updated at the clock edge):
  - If alo=1: carry_flag <= c, zero_flag <= (r == 0).
  - If alo=0: carry_flag <= 0, zero_flag <= (A == 0). Here A is the current registered value; this covers the LDA/LDI flag update in the step after A is loaded.
  - fe=0: both flags hold.
- ALU result written back (alo=1 with ai=1):
  - A takes r. This works because bus_in carries r via the external bus mux.
  - Flags computed in that same cycle use the pre-edge A and B.
- Simultaneous ai and ao: A reloads bus_in with no special handling.
- Output register: oi=1 loads bus_in into out_data. out_valid is a registered copy of oi, high exactly one cycle after the load edge. Back-to-back oi gives out_valid high on consecutive cycles.
- Latency:
  - Register loads and flags: visible one cycle after the enabling edge.
  - bus_out, bus_drive, bus_conflict: combinational, same cycle.
- All outputs except bus_out, bus_drive and bus_conflict are registered.

Optional Feature:
- Macro: ALU_OVERFLOW_FLAG_EN.
- Defined:
  - Extra output port overflow_flag (1 bit), reset to 0.
  - Updated only when fe=1 and alo=1, to signed two's-complement overflow of the operation. Add: operands share a sign and the result sign differs. Subtract: A and B differ in sign and the result sign differs from A.
  - fe=1 with alo=0 clears it to 0.
- Undefined: port absent; no overflow logic synthesized; all other behaviour identical.

Test Plan:
- Reset during activity: load A=0x55 and set flags, then assert reset for one edge -> a_val=0, out_data=0, carry_flag=0, zero_flag=0, out_valid=0 the next cycle.
- ADD with carry: A=0xF0, B=0x20, alo=ai=fe=1, bus_in looped from bus_out -> bus_out=0x10 before the edge; after the edge A=0x10, carry_flag=1, zero_flag=0.
- SUB to zero: A=0x07, B=0x07, sub=alo=ai=fe=1 -> r=0x00, carry_flag=1 (no borrow), zero_flag=1, A=0x00. Then A=0x03, B=0x05 -> r=0xFE, carry_flag=0, zero_flag=0.
- LDA-style flag update: ai=1 with bus_in=0x00, next cycle fe=1 with alo=0 -> zero_flag=1, carry_flag=0. Repeat with bus_in=0x01 -> zero_flag=0.
- Output strobe: ao=1, oi=1 with bus_in=bus_out and A=0x2A -> out_data=0x2A and a single-cycle out_valid one cycle later. With fe=0 throughout, flags are unchanged.
- Bus conflict and overflow (macro defined): ao=alo=1 -> bus_conflict=1 and bus_out equals the ALU result. A=0x7F, B=0x01, add with fe=1 -> overflow_flag=1, r=0x80.
